// File: rtl/ring_nic.sv
// ring_nic: one-packet-each-way network interface between a processing
// element and the PE port of a ring router. The PE sees four registers:
// input buffer, input status, output buffer and output status. Injection
// into the ring waits until the packet's VC bit matches the ring polarity.
module ring_nic #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              polarity,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out,
  input  logic              nicEn,
  input  logic              nicWrEn,
  output logic              net_so,
  input  logic              net_ro,
  output logic [DATA_W-1:0] net_do,
  input  logic              net_si,
  output logic              net_ri,
  input  logic [DATA_W-1:0] net_di
);

  localparam logic [1:0] ADDR_IN_BUF   = 2'b00;
  localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
  localparam logic [1:0] ADDR_OUT_BUF  = 2'b10;
  localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

  logic [DATA_W-1:0] in_buf_q,  in_buf_d;
  logic              in_full_q, in_full_d;
  logic [DATA_W-1:0] out_buf_q, out_buf_d;
  logic              out_full_q, out_full_d;
  logic [DATA_W-1:0] d_out_q,   d_out_d;

  logic              pe_rd;
  logic              pe_wr;

  // Router-facing handshakes come straight from registered state; net_so
  // also folds in the router's ready and the current VC phase.
  assign net_ri = ~in_full_q;
  assign net_do = out_buf_q;
  assign net_so = out_full_q & net_ro & (out_buf_q[DATA_W-1] == polarity);
  assign d_out  = d_out_q;

  assign pe_rd = nicEn & ~nicWrEn;
  assign pe_wr = nicEn &  nicWrEn;

  // Next-state for both channel buffers and the read register. Every
  // decision looks at the flags as they stood at the start of the cycle,
  // so a PE write racing a departing packet is dropped, and an arrival can
  // never coincide with a pop (one needs empty, the other full).
  always_comb begin
    in_buf_d   = in_buf_q;
    in_full_d  = in_full_q;
    out_buf_d  = out_buf_q;
    out_full_d = out_full_q;
    d_out_d    = d_out_q;

    // Router to NIC: accept only into an empty buffer; a send while full
    // is a router protocol error and is ignored.
    if (net_si && !in_full_q) begin
      in_buf_d  = net_di;
      in_full_d = 1'b1;
    end

    // NIC to router: the packet leaves on the cycle net_so is high.
    if (net_so) begin
      out_full_d = 1'b0;
    end

    // PE write: only the output buffer is writable, and only when empty.
    if (pe_wr && (addr == ADDR_OUT_BUF) && !out_full_q) begin
      out_buf_d  = d_in;
      out_full_d = 1'b1;
    end

    // PE read: registered, one cycle of latency. Popping an empty input
    // buffer returns its stale contents without touching any flag.
    if (pe_rd) begin
      unique case (addr)
        ADDR_IN_BUF: begin
          d_out_d = in_buf_q;
          if (in_full_q) begin
            in_full_d = 1'b0;
          end
        end
        ADDR_IN_STAT:  d_out_d = {{(DATA_W-1){1'b0}}, in_full_q};
        ADDR_OUT_BUF:  d_out_d = out_buf_q;
        ADDR_OUT_STAT: d_out_d = {{(DATA_W-1){1'b0}}, out_full_q};
        default:       d_out_d = d_out_q;
      endcase
    end
  end

  // State registers; reset discards any buffered packet in either direction.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_buf_q   <= '0;
      in_full_q  <= 1'b0;
      out_buf_q  <= '0;
      out_full_q <= 1'b0;
      d_out_q    <= '0;
    end else begin
      in_buf_q   <= in_buf_d;
      in_full_q  <= in_full_d;
      out_buf_q  <= out_buf_d;
      out_full_q <= out_full_d;
      d_out_q    <= d_out_d;
    end
  end

endmodule

// File: tb/tb_ring_nic.sv
// Directed bench for ring_nic: reset, injection with VC gating,
// back-pressure, reception, empty read, same-cycle races, mid-run reset.
module tb_ring_nic;
  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic              polarity;
  logic [1:0]        addr;
  logic [DATA_W-1:0] d_in;
  logic [DATA_W-1:0] d_out;
  logic              nicEn;
  logic              nicWrEn;
  logic              net_so;
  logic              net_ro;
  logic [DATA_W-1:0] net_do;
  logic              net_si;
  logic              net_ri;
  logic [DATA_W-1:0] net_di;

  int checks   = 0;
  int failures = 0;

  ring_nic #(.DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .polarity(polarity), .addr(addr),
    .d_in(d_in), .d_out(d_out), .nicEn(nicEn), .nicWrEn(nicWrEn),
    .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
    .net_si(net_si), .net_ri(net_ri), .net_di(net_di)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; the DUT samples them at the next rise.
  task automatic pe_write(input logic [1:0] a, input logic [DATA_W-1:0] v);
    nicEn = 1'b1; nicWrEn = 1'b1; addr = a; d_in = v;
    @(negedge clk);
    nicEn = 1'b0; nicWrEn = 1'b0;
  endtask

  task automatic pe_read(input logic [1:0] a);
    nicEn = 1'b1; nicWrEn = 1'b0; addr = a;
    @(negedge clk);
    nicEn = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; polarity = 1'b0; addr = 2'b00; d_in = '0;
    nicEn = 1'b0; nicWrEn = 1'b0; net_ro = 1'b0; net_si = 1'b0; net_di = '0;
    repeat (2) @(negedge clk);
    checks++; if (net_so !== 1'b0) begin failures++; $display("FAIL reset_net_so got=%b exp=0", net_so); end
    checks++; if (net_ri !== 1'b1) begin failures++; $display("FAIL reset_net_ri got=%b exp=1", net_ri); end
    checks++; if (d_out !== 64'h0) begin failures++; $display("FAIL reset_d_out got=%h exp=0", d_out); end
    checks++; if (net_do !== 64'h0) begin failures++; $display("FAIL reset_net_do got=%h exp=0", net_do); end
    reset = 1'b0;
    pe_read(2'b01);
    checks++; if (d_out !== 64'h0) begin failures++; $display("FAIL reset_in_stat got=%h exp=0", d_out); end
    pe_read(2'b11);
    checks++; if (d_out !== 64'h0) begin failures++; $display("FAIL reset_out_stat got=%h exp=0", d_out); end
  endtask

  task automatic test_inject;
    polarity = 1'b0; net_ro = 1'b1;
    pe_write(2'b10, 64'h8000_0000_0000_00A5);
    for (int i = 0; i < 3; i++) begin
      checks++; if (net_so !== 1'b0) begin failures++; $display("FAIL inject_wrong_phase cyc=%0d got=%b exp=0", i, net_so); end
      @(negedge clk);
    end
    polarity = 1'b1; #1;
    checks++; if (net_so !== 1'b1) begin failures++; $display("FAIL inject_so got=%b exp=1", net_so); end
    checks++; if (net_do !== 64'h8000_0000_0000_00A5) begin failures++; $display("FAIL inject_do got=%h exp=8000_0000_0000_00a5", net_do); end
    @(negedge clk);
    checks++; if (net_so !== 1'b0) begin failures++; $display("FAIL inject_one_shot got=%b exp=0", net_so); end
    pe_read(2'b11);
    checks++; if (d_out !== 64'h0) begin failures++; $display("FAIL inject_out_stat got=%h exp=0", d_out); end
  endtask

  task automatic test_back_pressure;
    net_ro = 1'b0; polarity = 1'b1;
    pe_write(2'b10, 64'h8000_0000_0000_0077);
    pe_write(2'b10, 64'h0000_0000_0000_1234);
    for (int i = 0; i < 5; i++) begin
      checks++; if (net_so !== 1'b0) begin failures++; $display("FAIL bp_so cyc=%0d got=%b exp=0", i, net_so); end
      checks++; if (net_do !== 64'h8000_0000_0000_0077) begin failures++; $display("FAIL bp_do cyc=%0d got=%h exp=8000_0000_0000_0077", i, net_do); end
      @(negedge clk);
    end
    pe_read(2'b10);
    checks++; if (d_out !== 64'h8000_0000_0000_0077) begin failures++; $display("FAIL bp_rd_outbuf got=%h exp=8000_0000_0000_0077", d_out); end
    pe_read(2'b11);
    checks++; if (d_out !== 64'h1) begin failures++; $display("FAIL bp_out_stat_full got=%h exp=1", d_out); end
    net_ro = 1'b1; #1;
    checks++; if (net_so !== 1'b1) begin failures++; $display("FAIL bp_release_so got=%b exp=1", net_so); end
    @(negedge clk);
    checks++; if (net_so !== 1'b0) begin failures++; $display("FAIL bp_after_so got=%b exp=0", net_so); end
    pe_read(2'b11);
    checks++; if (d_out !== 64'h0) begin failures++; $display("FAIL bp_out_stat_empty got=%h exp=0", d_out); end
  endtask

  task automatic test_receive;
    // Arrival and a status read in the same cycle: the read sees the old flag.
    net_si = 1'b1; net_di = 64'hDEAD_BEEF_0000_0001;
    nicEn = 1'b1; nicWrEn = 1'b0; addr = 2'b01; #1;
    checks++; if (net_ri !== 1'b1) begin failures++; $display("FAIL rx_ri_before got=%b exp=1", net_ri); end
    @(negedge clk);
    net_si = 1'b0; nicEn = 1'b0;
    checks++; if (d_out !== 64'h0) begin failures++; $display("FAIL rx_stat_pre_edge got=%h exp=0", d_out); end
    checks++; if (net_ri !== 1'b0) begin failures++; $display("FAIL rx_ri_full got=%b exp=0", net_ri); end
    pe_read(2'b01);
    checks++; if (d_out !== 64'h1) begin failures++; $display("FAIL rx_in_stat got=%h exp=1", d_out); end
    // A send while full is ignored.
    net_si = 1'b1; net_di = 64'h5555_5555_5555_5555;
    @(negedge clk);
    net_si = 1'b0;
    pe_read(2'b00);
    checks++; if (d_out !== 64'hDEAD_BEEF_0000_0001) begin failures++; $display("FAIL rx_data got=%h exp=dead_beef_0000_0001", d_out); end
    checks++; if (net_ri !== 1'b1) begin failures++; $display("FAIL rx_ri_after_pop got=%b exp=1", net_ri); end
    pe_read(2'b01);
    checks++; if (d_out !== 64'h0) begin failures++; $display("FAIL rx_in_stat_empty got=%h exp=0", d_out); end
  endtask

  task automatic test_empty_read;
    pe_read(2'b00);
    checks++; if (d_out !== 64'hDEAD_BEEF_0000_0001) begin failures++; $display("FAIL empty_rd_stale got=%h exp=dead_beef_0000_0001", d_out); end
    checks++; if (net_ri !== 1'b1) begin failures++; $display("FAIL empty_rd_ri got=%b exp=1", net_ri); end
    pe_read(2'b01);
    checks++; if (d_out !== 64'h0) begin failures++; $display("FAIL empty_rd_stat got=%h exp=0", d_out); end
  endtask

  task automatic test_back_to_back;
    // Packet with VC bit 0 waits on phase 1, then a write races its departure.
    polarity = 1'b1; net_ro = 1'b1;
    pe_write(2'b10, 64'h0000_0000_0000_0042);
    checks++; if (net_so !== 1'b0) begin failures++; $display("FAIL b2b_wait got=%b exp=0", net_so); end
    polarity = 1'b0;
    nicEn = 1'b1; nicWrEn = 1'b1; addr = 2'b10; d_in = 64'h0000_0000_0000_9999; #1;
    checks++; if (net_so !== 1'b1) begin failures++; $display("FAIL b2b_so got=%b exp=1", net_so); end
    @(negedge clk);
    nicEn = 1'b0; nicWrEn = 1'b0;
    checks++; if (net_so !== 1'b0) begin failures++; $display("FAIL b2b_write_dropped_so got=%b exp=0", net_so); end
    pe_read(2'b10);
    checks++; if (d_out !== 64'h0000_0000_0000_0042) begin failures++; $display("FAIL b2b_outbuf got=%h exp=42", d_out); end
    pe_read(2'b11);
    checks++; if (d_out !== 64'h0) begin failures++; $display("FAIL b2b_out_stat got=%h exp=0", d_out); end
  endtask

  task automatic test_reset_mid;
    net_si = 1'b1; net_di = 64'h0000_0000_0000_1111;
    @(negedge clk);
    net_si = 1'b0; net_ro = 1'b0; polarity = 1'b1;
    pe_write(2'b10, 64'h8000_0000_0000_00BB);
    checks++; if (net_ri !== 1'b0) begin failures++; $display("FAIL rm_in_full got=%b exp=0", net_ri); end
    net_ro = 1'b1; reset = 1'b1; #1;
    checks++; if (net_so !== 1'b1) begin failures++; $display("FAIL rm_so_pre got=%b exp=1", net_so); end
    @(negedge clk);
    reset = 1'b0;
    checks++; if (net_ri !== 1'b1) begin failures++; $display("FAIL rm_ri got=%b exp=1", net_ri); end
    checks++; if (net_do !== 64'h0) begin failures++; $display("FAIL rm_do got=%h exp=0", net_do); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (net_so !== 1'b0) begin failures++; $display("FAIL rm_no_so cyc=%0d got=%b exp=0", i, net_so); end
      @(negedge clk);
    end
    pe_read(2'b01);
    checks++; if (d_out !== 64'h0) begin failures++; $display("FAIL rm_in_stat got=%h exp=0", d_out); end
    pe_read(2'b11);
    checks++; if (d_out !== 64'h0) begin failures++; $display("FAIL rm_out_stat got=%h exp=0", d_out); end
  endtask

  initial begin
    test_reset;
    test_inject;
    test_back_pressure;
    test_receive;
    test_empty_read;
    test_back_to_back;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ring_nic.md
# ring_nic

Network interface between a processing element (PE) and the PE port of a ring `router`. It holds one 64-bit packet in each direction and presents a four-register memory-mapped view to the PE:
- an output channel buffer that injects into the router's `pesi/peri/pedi` port;
- an input channel buffer that accepts from the router's `peso/pero/pedo` port.

Injection is gated by the ring's virtual-channel polarity, so packets enter the router only on their own VC phase.

## Interface
Parameters
- DATA_W, 64, packet / register width (bit DATA_W-1 is the VC bit)

Ports
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- polarity  in  1  ring VC phase; same signal that drives the router
- addr  in  2  register select: 00 input buffer, 01 input status, 10 output buffer, 11 output status
- d_in  in  DATA_W  PE write data
- d_out  out  DATA_W  PE read data (registered)
- nicEn  in  1  PE access enable
- nicWrEn  in  1  1 = write, 0 = read (qualified by nicEn)
- net_so  out  1  send to router; connects to router `pesi`
- net_ro  in  1  router ready; connects to router `peri`
- net_do  out  DATA_W  packet to router; connects to router `pedi`
- net_si  in  1  router sending; connects to router `peso`
- net_ri  out  1  NIC ready; connects to router `pero`
- net_di  in  DATA_W  packet from router; connects to router `pedo`

## Operation
- State consists of:
  - `in_buf` (DATA_W) and `in_full`;
  - `out_buf` (DATA_W) and `out_full`;
  - the `d_out` register.
- Reset:
  - `in_full = 0`, `out_full = 0`;
  - `in_buf = 0`, `out_buf = 0`;
  - `d_out = 0`.
  - Consequences: `net_so = 0`, `net_ri = 1`, `net_do = 0`.
- Input channel (router to NIC):
  - `net_ri = ~in_full`.
  - When `net_si & net_ri`: `in_buf <= net_di` and `in_full <= 1`.
  - `net_si` while `in_full` is a router protocol error; the NIC ignores it and the buffer is unchanged.
- Output channel (NIC to router):
  - `net_do = out_buf`.
  - `net_so = out_full & net_ro & (out_buf[DATA_W-1] == polarity)`. This is combinational from registered state plus inputs.
  - When `net_so`: `out_full <= 0` at that edge.
- PE accesses (effective when `nicEn`):
  - Read 00: `d_out <= in_buf`. If `in_full`, `in_full <= 0`. Reading an empty buffer returns stale data and changes no state.
  - Read 01: `d_out <= {0…, in_full}`.
  - Read 10: `d_out <= out_buf` (debug; no side effect).
  - Read 11: `d_out <= {0…, out_full}`.
  - Write 10: if `~out_full`, then `out_buf <= d_in` and `out_full <= 1`. If full, the write is dropped silently.
  - Writes to 00, 01 and 11 have no effect.
  - When `nicEn = 0`, or the access is a write, `d_out` holds its value.
- Simultaneous events:
  - All decisions use flag values at the start of the cycle.
  - A PE write to 10 in the same cycle that `net_so` fires is dropped, because `out_full` was 1.
  - Router arrival and a PE read of 00 cannot both take effect in one cycle: arrival needs empty, the pop needs full.
  - A status read in the cycle a flag changes returns the pre-edge value.
- A reset asserted at any point wins over every concurrent access or transfer. Buffered packets are discarded.

## Timing
- PE read latency is 1 cycle: `d_out` is valid after the edge that samples the read.
- Router to PE:
  - a packet accepted at edge N is visible as `in_full = 1` after N;
  - the earliest read of 00 samples at edge N+1.
- PE to router:
  - a write at edge N makes `out_full = 1` after N;
  - `net_so` can assert in cycle N+1 if `net_ro` is high and the VC bit equals `polarity`;
  - otherwise the packet waits, up to one polarity period while only the VC phase is wrong.
- Maximum throughput is one packet per 2 cycles per direction with alternating polarity.

## Test plan
- Reset: hold `reset` 2 cycles → `net_so = 0`, `net_ri = 1`, `d_out = 0`; reads of 01 and 11 return 0.
- Inject:
  - Setup: write 10 with `0x8000_0000_0000_00A5`, `net_ro = 1`.
  - Stimulus: `polarity = 0`, then `1`.
  - Required response: `net_so` stays 0 while `polarity = 0`, then asserts for exactly one cycle with `net_do = 0x8000_0000_0000_00A5`. A following read of 11 returns 0.
- Back-pressure:
  - Setup: `out_full` set, `net_ro = 0` for 5 cycles.
  - Stimulus: a second write of `0x1234`.
  - Required response: the second write is dropped; `net_do` keeps the first packet and is sent once `net_ro = 1` and the phase matches.
- Receive:
  - Stimulus: router drives `net_si = 1` with `0xDEAD_BEEF_0000_0001`.
  - Required response: `net_ri` drops the next cycle; a read of 01 returns 1; a read of 00 returns `0xDEAD_BEEF_0000_0001` one cycle later; `net_ri` returns to 1.
- Empty read: read 00 with `in_full = 0` → `d_out` equals the stale `in_buf` and `in_full` stays 0.
- Reset mid-operation: both buffers full, assert `reset` during a `net_so` cycle → both flags 0 after the edge and no further `net_so`.
